// File: rtl/udp_wide_payload_send.sv
// Serializes a frame header plus WORD_W-bit payload words into the byte-wide UDP TX core.
// Optional statistics counters are enabled with `define UDP_SEND_STATS_EN.
module udp_wide_payload_send #(
  parameter int WORD_W    = 128,
  parameter int HDR_BYTES = 2,
  parameter int IDX_W     = 8
) (
  input  logic                   i_udp_clk50m,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [HDR_BYTES*8-1:0] i_hdr,
  input  logic [15:0]            i_payload_len,
  input  logic [15:0]            i_ipv4_sign,
  input  logic [WORD_W-1:0]      i_word_data,
  output logic                   o_word_req,
  output logic [IDX_W-1:0]       o_word_idx,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_abort,
  output logic [2:0]             o_state,
  output logic                   o_udp_tx_en,
  output logic                   o_udp_tx_de,
  output logic [7:0]             o_udp_data,
  output logic [15:0]            o_udp_data_len,
  output logic [15:0]            o_ipv4_sign,
`ifdef UDP_SEND_STATS_EN
  output logic [15:0]            o_frames_sent,
  output logic [15:0]            o_frames_aborted,
  output logic [31:0]            o_bytes_sent,
`endif
  input  logic                   i_udp_head_down,
  input  logic                   i_udp_busy,
  input  logic                   i_udp_isLoadData
);

  localparam int BPW   = WORD_W / 8;
  localparam int HDR_W = HDR_BYTES * 8;
  localparam int BUF_W = (WORD_W > HDR_W) ? WORD_W : HDR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEAD    = 3'd1,
    S_HDR     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, hdr_al, word_al;
  logic [15:0]      len_q, len_d, byte_cnt, byte_cnt_d, byte_nxt, pos_q, pos_d, dlen_d;
  logic [3:0]       hdr_cnt, hdr_cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             busy_d, tx_en_d, tx_de_d, req_d, done_d, abort_d, consume, pay_c;

  // Header and payload words are both left-aligned so the next byte is always the buffer MSB.
  assign hdr_al   = BUF_W'(i_hdr) << (BUF_W - HDR_W);
  assign word_al  = BUF_W'(i_word_data) << (BUF_W - WORD_W);
  assign consume  = i_udp_head_down & i_udp_isLoadData;
  assign byte_nxt = byte_cnt + 16'd1;
  assign pay_c    = (state == S_PAYLOAD) & consume & i_udp_busy;

  assign o_state    = state;
  assign o_udp_data = buf_q[BUF_W-1 -: 8];

  always_comb begin
    state_d    = state;
    buf_d      = buf_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt;
    pos_d      = pos_q;
    hdr_cnt_d  = hdr_cnt;
    idx_d      = o_word_idx;
    dlen_d     = o_udp_data_len;
    busy_d     = o_busy;
    tx_en_d    = o_udp_tx_en;
    tx_de_d    = o_udp_tx_de;
    req_d      = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_en) begin
          state_d    = S_HEAD;
          busy_d     = 1'b1;
          tx_en_d    = 1'b1;
          len_d      = i_payload_len;
          dlen_d     = i_payload_len + 16'(HDR_BYTES);
          idx_d      = '0;
          hdr_cnt_d  = '0;
          byte_cnt_d = '0;
          pos_d      = '0;
        end
      end
      S_HEAD: begin
        if (i_udp_head_down) begin
          state_d = S_HDR;
          buf_d   = hdr_al;
          tx_en_d = 1'b0;
          tx_de_d = 1'b1;
        end
      end
      S_HDR, S_PAYLOAD: begin
        // Losing the UDP core mid-frame takes priority over a byte consumed in the same cycle.
        if (!i_udp_busy) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
          busy_d  = 1'b0;
          tx_en_d = 1'b0;
          tx_de_d = 1'b0;
        end else if (consume && state == S_HDR) begin
          if (hdr_cnt == 4'(HDR_BYTES - 1)) begin
            if (len_q == 16'd0) begin
              state_d = S_FINISH;
              done_d  = 1'b1;
              buf_d   = buf_q << 8;
            end else begin
              state_d = S_PAYLOAD;
              buf_d   = word_al;
              req_d   = 1'b1;
              idx_d   = o_word_idx + IDX_W'(1);
              pos_d   = '0;
            end
          end else begin
            buf_d     = buf_q << 8;
            hdr_cnt_d = hdr_cnt + 4'd1;
          end
        end else if (consume) begin
          byte_cnt_d = byte_nxt;
          if (byte_nxt == len_q) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            buf_d   = buf_q << 8;
          end else if (pos_q == 16'(BPW - 1)) begin
            buf_d = word_al;
            req_d = 1'b1;
            idx_d = o_word_idx + IDX_W'(1);
            pos_d = '0;
          end else begin
            buf_d = buf_q << 8;
            pos_d = pos_q + 16'd1;
          end
        end
      end
      S_FINISH: begin
        if (!i_udp_busy) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          tx_de_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      buf_q          <= '0;
      len_q          <= '0;
      byte_cnt       <= '0;
      pos_q          <= '0;
      hdr_cnt        <= '0;
      o_word_idx     <= '0;
      o_udp_data_len <= '0;
      o_busy         <= 1'b0;
      o_udp_tx_en    <= 1'b0;
      o_udp_tx_de    <= 1'b0;
      o_word_req     <= 1'b0;
      o_frame_done   <= 1'b0;
      o_abort        <= 1'b0;
      o_ipv4_sign    <= '0;
    end else begin
      state          <= state_d;
      buf_q          <= buf_d;
      len_q          <= len_d;
      byte_cnt       <= byte_cnt_d;
      pos_q          <= pos_d;
      hdr_cnt        <= hdr_cnt_d;
      o_word_idx     <= idx_d;
      o_udp_data_len <= dlen_d;
      o_busy         <= busy_d;
      o_udp_tx_en    <= tx_en_d;
      o_udp_tx_de    <= tx_de_d;
      o_word_req     <= req_d;
      o_frame_done   <= done_d;
      o_abort        <= abort_d;
      o_ipv4_sign    <= i_ipv4_sign;
    end
  end

`ifdef UDP_SEND_STATS_EN
  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frames_sent    <= '0;
      o_frames_aborted <= '0;
      o_bytes_sent     <= '0;
    end else begin
      if (done_d && o_frames_sent != 16'hFFFF)       o_frames_sent    <= o_frames_sent + 16'd1;
      if (abort_d && o_frames_aborted != 16'hFFFF)   o_frames_aborted <= o_frames_aborted + 16'd1;
      if (pay_c && o_bytes_sent != 32'hFFFF_FFFF)    o_bytes_sent     <= o_bytes_sent + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_wide_payload_send.sv
// Directed bench: two serializer instances (128-bit and 64-bit words) driven by one UDP core model.
module tb_udp_wide_payload_send;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] hdr = '0;
  logic [15:0] plen = '0;
  logic [15:0] sign = 16'hBEEF;
  logic        head_down = 1'b0, udp_busy = 1'b0, is_load = 1'b0;

  logic [127:0] w128;
  logic [63:0]  w64;
  logic [7:0]   idx128, idx64;
  logic         req128, req64, done128, done64, ab128, ab64;
  logic         busy128, busy64, txen128, txen64, txde128, txde64;
  logic [2:0]   st128, st64;
  logic [7:0]   d128, d64;
  logic [15:0]  dlen128, dlen64, sg128, sg64;
`ifdef UDP_SEND_STATS_EN
  logic [15:0] fs128, fs64, fa128, fa64;
  logic [31:0] bs128, bs64;
  int exp_fs = 0, exp_fa = 0, exp_bs = 0;
`endif

  int total = 0;
  int bad = 0;
  int n_req128 = 0, n_req64 = 0, n_done128 = 0, n_done64 = 0, n_ab128 = 0, n_ab64 = 0;

  always #10 clk = ~clk;

  udp_wide_payload_send #(.WORD_W(128), .HDR_BYTES(2), .IDX_W(8)) u128 (
    .i_udp_clk50m(clk), .i_rst_n(rst_n), .i_en(en), .i_hdr(hdr), .i_payload_len(plen),
    .i_ipv4_sign(sign), .i_word_data(w128), .o_word_req(req128), .o_word_idx(idx128),
    .o_busy(busy128), .o_frame_done(done128), .o_abort(ab128), .o_state(st128),
    .o_udp_tx_en(txen128), .o_udp_tx_de(txde128), .o_udp_data(d128),
    .o_udp_data_len(dlen128), .o_ipv4_sign(sg128),
`ifdef UDP_SEND_STATS_EN
    .o_frames_sent(fs128), .o_frames_aborted(fa128), .o_bytes_sent(bs128),
`endif
    .i_udp_head_down(head_down), .i_udp_busy(udp_busy), .i_udp_isLoadData(is_load)
  );

  udp_wide_payload_send #(.WORD_W(64), .HDR_BYTES(2), .IDX_W(8)) u64 (
    .i_udp_clk50m(clk), .i_rst_n(rst_n), .i_en(en), .i_hdr(hdr), .i_payload_len(plen),
    .i_ipv4_sign(sign), .i_word_data(w64), .o_word_req(req64), .o_word_idx(idx64),
    .o_busy(busy64), .o_frame_done(done64), .o_abort(ab64), .o_state(st64),
    .o_udp_tx_en(txen64), .o_udp_tx_de(txde64), .o_udp_data(d64),
    .o_udp_data_len(dlen64), .o_ipv4_sign(sg64),
`ifdef UDP_SEND_STATS_EN
    .o_frames_sent(fs64), .o_frames_aborted(fa64), .o_bytes_sent(bs64),
`endif
    .i_udp_head_down(head_down), .i_udp_busy(udp_busy), .i_udp_isLoadData(is_load)
  );

  // Upstream word source: payload byte n carries n ^ 8'hA5, word k holds bytes k*BPW.. MSB first.
  always_comb begin
    w128 = '0;
    w64  = '0;
    for (int j = 0; j < 16; j++) w128[127-8*j -: 8] = 8'(int'(idx128) * 16 + j) ^ 8'hA5;
    for (int j = 0; j < 8; j++)  w64[63-8*j -: 8]   = 8'(int'(idx64) * 8 + j) ^ 8'hA5;
  end

  // Pulse monitor: counts high cycles, so a two-cycle pulse counts twice.
  always @(negedge clk) begin
    if (req128)  n_req128++;
    if (req64)   n_req64++;
    if (done128) n_done128++;
    if (done64)  n_done64++;
    if (ab128)   n_ab128++;
    if (ab64)    n_ab64++;
  end

  typedef struct {
    int          len;
    logic [15:0] hdr;
    int          abort_after;
    int          reqs128;
    int          reqs64;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int b_req128, b_req64, b_done128, b_done64, b_ab128, b_ab64, nb, p;
    logic [7:0] eb;
    b_req128 = n_req128; b_req64 = n_req64; b_done128 = n_done128;
    b_done64 = n_done64; b_ab128 = n_ab128; b_ab64 = n_ab64;
    @(negedge clk);
    en = 1'b1; plen = 16'(v.len); hdr = v.hdr; udp_busy = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("start_state", {29'd0, st128}, 32'd1);
    chk("start_tx_en", {31'd0, txen128}, 32'd1);
    chk("start_busy", {30'd0, busy128, busy64}, 32'd3);
    chk("start_idx", {16'd0, idx128, idx64}, 32'd0);
    chk("data_len", {dlen128, dlen64}, {16'(v.len + 2), 16'(v.len + 2)});
    @(negedge clk);
    head_down = 1'b1;
    @(negedge clk);
    chk("hdr_state", {26'd0, st128, st64}, {26'd0, 3'd2, 3'd2});
    chk("hdr_tx", {28'd0, txen128, txde128, txen64, txde64}, 32'h5);
    nb = (v.abort_after >= 0) ? 2 + v.abort_after : 2 + v.len;
    for (int n = 0; n < nb; n++) begin
      if (n == 0)      eb = v.hdr[15:8];
      else if (n == 1) eb = v.hdr[7:0];
      else begin
        p  = n - 2;
        eb = 8'(p) ^ 8'hA5;
      end
      chk($sformatf("byte%0d_128", n), {24'd0, d128}, {24'd0, eb});
      chk($sformatf("byte%0d_64", n), {24'd0, d64}, {24'd0, eb});
      is_load = 1'b1;
      @(negedge clk);
      is_load = 1'b0;
      @(negedge clk);
    end
    if (v.abort_after >= 0) begin
      udp_busy = 1'b0;
      @(negedge clk);
      chk("abort_state", {26'd0, st128, st64}, 32'd0);
      chk("abort_busy", {28'd0, busy128, busy64, txde128, txde64}, 32'd0);
      head_down = 1'b0;
      @(negedge clk);
`ifdef UDP_SEND_STATS_EN
      exp_fa++;
      exp_bs += v.abort_after;
`endif
    end else begin
      chk("finish_state", {26'd0, st128, st64}, {26'd0, 3'd4, 3'd4});
      chk("finish_busy", {30'd0, busy128, busy64}, 32'd3);
      udp_busy = 1'b0;
      head_down = 1'b0;
      @(negedge clk);
      chk("idle_state", {26'd0, st128, st64}, 32'd0);
      chk("idle_busy", {28'd0, busy128, busy64, txde128, txde64}, 32'd0);
`ifdef UDP_SEND_STATS_EN
      exp_fs++;
      exp_bs += v.len;
`endif
    end
    chk("reqs128", 32'(n_req128 - b_req128), 32'(v.reqs128));
    chk("reqs64", 32'(n_req64 - b_req64), 32'(v.reqs64));
    chk("end_idx", {16'd0, idx128, idx64}, {16'd0, 8'(v.reqs128), 8'(v.reqs64)});
    chk("done_cnt", {n_done128 - b_done128, n_done64 - b_done64} == 64'd0 ? 32'd0 :
        32'((n_done128 - b_done128) * 16 + (n_done64 - b_done64)),
        (v.abort_after < 0) ? 32'h11 : 32'h0);
    chk("abort_cnt", 32'((n_ab128 - b_ab128) * 16 + (n_ab64 - b_ab64)),
        (v.abort_after >= 0) ? 32'h11 : 32'h0);
  endtask

  initial begin
    vecs[0] = '{len: 40, hdr: 16'h8003, abort_after: -1, reqs128: 3, reqs64: 5};
    vecs[1] = '{len: 0,  hdr: 16'h1234, abort_after: -1, reqs128: 0, reqs64: 0};
    vecs[2] = '{len: 17, hdr: 16'hABCD, abort_after: -1, reqs128: 2, reqs64: 3};
    vecs[3] = '{len: 16, hdr: 16'h0F0F, abort_after: -1, reqs128: 1, reqs64: 2};
    vecs[4] = '{len: 1,  hdr: 16'hFFFF, abort_after: -1, reqs128: 1, reqs64: 1};
    vecs[5] = '{len: 40, hdr: 16'h5555, abort_after: 5,  reqs128: 1, reqs64: 1};

    repeat (2) @(negedge clk);
    chk("rst_state", {26'd0, st128, st64}, 32'd0);
    chk("rst_ctrl", {20'd0, busy128, busy64, txen128, txen64, txde128, txde64,
        req128, req64, done128, done64, ab128, ab64}, 32'd0);
    chk("rst_data", {d128, d64, idx128, idx64}, 32'd0);
    chk("rst_len_sign", {dlen128, sg128}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ipv4_sign", {sg128, sg64}, 32'hBEEF_BEEF);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset in the middle of a payload: everything clears asynchronously.
    @(negedge clk);
    en = 1'b1; plen = 16'd40; hdr = 16'h8003; udp_busy = 1'b1;
    @(negedge clk);
    en = 1'b0; head_down = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      is_load = 1'b1;
      @(negedge clk);
      is_load = 1'b0;
      @(negedge clk);
    end
    chk("mid_state", {26'd0, st128, st64}, {26'd0, 3'd3, 3'd3});
    rst_n = 1'b0;
    #1;
    chk("mrst_state", {26'd0, st128, st64}, 32'd0);
    chk("mrst_ctrl", {20'd0, busy128, busy64, txen128, txen64, txde128, txde64,
        req128, req64, done128, done64, ab128, ab64}, 32'd0);
    chk("mrst_data", {d128, d64, idx128, idx64}, 32'd0);
    chk("mrst_len", {dlen128, dlen64}, 32'd0);
`ifdef UDP_SEND_STATS_EN
    exp_fs = 0; exp_fa = 0; exp_bs = 0;
`endif
    @(negedge clk);
    head_down = 1'b0; udp_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[0]);
    run_frame(vecs[5]);
    run_frame(vecs[3]);

`ifdef UDP_SEND_STATS_EN
    chk("frames_sent", {fs128, fs64}, {16'(exp_fs), 16'(exp_fs)});
    chk("frames_aborted", {fa128, fa64}, {16'(exp_fa), 16'(exp_fa)});
    chk("bytes_sent128", bs128, 32'(exp_bs));
    chk("bytes_sent64", bs64, 32'(exp_bs));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
